// File: rtl/mnist_image_loader.sv
// mnist_image_loader: byte-stream writer for the classifier image buffer.
// Assembles LSB-first bytes into DATA_WIDTH-bit pixels, writes them
// sequentially, then kicks off compute and waits for its result-ready edge.
module mnist_image_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_A_L  = 784,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  abort,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  start_comp,
    input  logic                  comp_ready,
    output logic                  busy,
    output logic                  image_done
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(NB - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(ARRAY_A_L - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]     word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic                  comp_ready_prev_q, comp_ready_prev_d;
    logic                  in_ready_q, in_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  start_comp_q, start_comp_d;
    logic                  busy_q, busy_d;
    logic                  image_done_q, image_done_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] pixel;

    // in_ready is registered, so the handshake has no in_valid->in_ready path
    assign accept = in_valid & in_ready_q;

    // Merge the incoming byte into its slot of the held bytes (LSB first)
    always_comb begin
        pixel = asm_q;
        pixel[{byte_cnt_q, 3'b000} +: 8] = in_data;
    end

    // Next-state and registered-output logic for the load/compute sequence
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a signal
        // unassigned, which would infer a latch.
        state_d           = state_q;
        byte_cnt_d        = byte_cnt_q;
        word_cnt_d        = word_cnt_q;
        asm_d             = asm_q;
        comp_ready_prev_d = comp_ready;
        in_ready_d        = in_ready_q;
        wr_en_d           = 1'b0;
        wr_addr_d         = wr_addr_q;
        wr_data_d         = wr_data_q;
        start_comp_d      = 1'b0;
        busy_d            = busy_q;
        image_done_d      = 1'b0;

        if (abort) begin
            // Abort wins over a same-cycle byte, which is simply not used
            state_d    = S_LOAD;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            asm_d      = '0;
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    in_ready_d = 1'b1;
                    if (accept) begin
                        busy_d = 1'b1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            wr_en_d    = 1'b1;
                            wr_addr_d  = word_cnt_q;
                            wr_data_d  = pixel;
                            if (word_cnt_q == LAST_WORD) begin
                                // Drop in_ready on this edge so no byte of
                                // the next image slips in
                                state_d    = S_START;
                                in_ready_d = 1'b0;
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            asm_d      = pixel;
                        end
                    end
                end
                S_START: begin
                    in_ready_d   = 1'b0;
                    start_comp_d = 1'b1;
                    state_d      = S_WAIT;
                end
                S_WAIT: begin
                    in_ready_d = 1'b0;
                    // Only a fresh rising edge counts; a level left high from
                    // the previous image is ignored
                    if (comp_ready && !comp_ready_prev_q) begin
                        state_d      = S_DONE;
                        image_done_d = 1'b1;
                        busy_d       = 1'b0;
                    end
                end
                S_DONE: begin
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    in_ready_d = 1'b1;
                    state_d    = S_LOAD;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    // State and output registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_LOAD;
            byte_cnt_q        <= '0;
            word_cnt_q        <= '0;
            asm_q             <= '0;
            comp_ready_prev_q <= 1'b0;
            in_ready_q        <= 1'b0;
            wr_en_q           <= 1'b0;
            wr_addr_q         <= '0;
            wr_data_q         <= '0;
            start_comp_q      <= 1'b0;
            busy_q            <= 1'b0;
            image_done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q           <= state_d;
            byte_cnt_q        <= byte_cnt_d;
            word_cnt_q        <= word_cnt_d;
            asm_q             <= asm_d;
            comp_ready_prev_q <= comp_ready_prev_d;
            in_ready_q        <= in_ready_d;
            wr_en_q           <= wr_en_d;
            wr_addr_q         <= wr_addr_d;
            wr_data_q         <= wr_data_d;
            start_comp_q      <= start_comp_d;
            busy_q            <= busy_d;
            image_done_q      <= image_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign start_comp = start_comp_q;
    assign busy       = busy_q;
    assign image_done = image_done_q;

endmodule

// File: tb/tb_mnist_image_loader.sv
// Directed bench for mnist_image_loader: full-rate and gapped image loads,
// stale comp_ready handling, abort, asynchronous reset and sign-bit pixels.
module tb_mnist_image_loader;

    localparam int DW = 16;
    localparam int L  = 784;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          abort = 1'b0;
    logic          comp_ready = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start_comp;
    logic          busy;
    logic          image_done;

    int  vec_cnt = 0;
    int  miss_cnt = 0;
    int  cyc = 0;
    int  last_wr_cyc = -10;
    int  wr_seen = 0;
    int  start_cnt = 0;
    int  done_cnt = 0;
    int  exp_k = 0;
    bit  mon_en = 1'b0;

    mnist_image_loader #(
        .DATA_WIDTH (DW),
        .ARRAY_A_L  (L),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .abort      (abort),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start_comp (start_comp),
        .comp_ready (comp_ready),
        .busy       (busy),
        .image_done (image_done)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", vec_cnt, miss_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write/start/done monitor: pixel k must land at address k with data k
    always @(negedge clk) begin
        cyc++;
        if (reset_n && wr_en) begin
            wr_seen++;
            last_wr_cyc = cyc;
            if (mon_en) begin
                check("wr_addr_seq", 32'(wr_addr), 32'(exp_k[AW-1:0]));
                check("wr_data_seq", 32'(wr_data), 32'(exp_k[DW-1:0]));
                exp_k++;
            end
        end
        if (reset_n && start_comp) begin
            start_cnt++;
            check("start_latency", cyc, last_wr_cyc + 1);
        end
        if (reset_n && image_done) done_cnt++;
    end

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            in_valid = 1'b0;
            repeat (n) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("handshake_timeout", 32'(t), 32'(0));
        @(negedge clk);
    endtask

    // Pixel k is sent as (k & 0xFF, k >> 8)
    task automatic send_stream(input int nbytes, input bit gaps);
        for (int j = 0; j < nbytes; j++) begin
            logic [15:0] kk;
            kk = 16'(j >> 1);
            send_byte((j % 2 == 1) ? kk[15:8] : kk[7:0], gaps);
        end
        in_valid = 1'b0;
    endtask

    // Drop comp_ready for three cycles, raise it, expect one image_done
    task automatic finish_image();
        comp_ready = 1'b0;
        repeat (3) @(negedge clk);
        comp_ready = 1'b1;
        @(negedge clk);
        check("image_done_pulse", 32'(image_done), 32'(1));
        check("busy_clear_done", 32'(busy), 32'(0));
        @(negedge clk);
        check("image_done_single", 32'(image_done), 32'(0));
        check("in_ready_after_done", 32'(in_ready), 32'(1));
    endtask

    initial begin
        int ws0;
        int ws1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_wr_en", 32'(wr_en), 32'(0));
        check("rst_wr_addr", 32'(wr_addr), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_start_comp", 32'(start_comp), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_image_done", 32'(image_done), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_rise", 32'(in_ready), 32'(1));

        // Full-rate image
        exp_k  = 0;
        mon_en = 1'b1;
        ws0    = wr_seen;
        send_stream(2 * L, 1'b0);
        repeat (5) @(negedge clk);
        check("img1_writes", 32'(wr_seen - ws0), 32'(L));
        check("img1_start_cnt", 32'(start_cnt), 32'(1));
        check("img1_in_ready_low", 32'(in_ready), 32'(0));
        check("img1_busy", 32'(busy), 32'(1));
        finish_image();
        check("img1_done_cnt", 32'(done_cnt), 32'(1));

        // Gapped image with comp_ready left high from before (stale)
        exp_k = 0;
        ws0   = wr_seen;
        send_stream(2 * L, 1'b1);
        repeat (10) @(negedge clk);
        check("img2_writes", 32'(wr_seen - ws0), 32'(L));
        check("img2_start_cnt", 32'(start_cnt), 32'(2));
        check("img2_stale_no_done", 32'(done_cnt), 32'(1));
        check("img2_in_ready_low", 32'(in_ready), 32'(0));
        finish_image();
        check("img2_done_cnt", 32'(done_cnt), 32'(2));

        // Partial image then abort, with a byte offered in the abort cycle
        exp_k = 0;
        ws0   = wr_seen;
        send_stream(301, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_pre_writes", 32'(wr_seen - ws0), 32'(150));
        check("abort_pre_busy", 32'(busy), 32'(1));
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_wr_en", 32'(wr_en), 32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(1));
        ws1 = wr_seen;
        repeat (5) @(negedge clk);
        check("abort_no_writes", 32'(wr_seen - ws1), 32'(0));

        // Fresh image after abort restarts at address 0 with clean pairing
        exp_k = 0;
        ws0   = wr_seen;
        send_stream(2 * L, 1'b0);
        repeat (5) @(negedge clk);
        check("img3_writes", 32'(wr_seen - ws0), 32'(L));
        check("img3_start_cnt", 32'(start_cnt), 32'(3));
        finish_image();

        // Asynchronous reset while the write of address 500 is on the bus
        exp_k = 0;
        send_stream(1002, 1'b0);
        check("pre_rst_wr_en", 32'(wr_en), 32'(1));
        check("pre_rst_wr_addr", 32'(wr_addr), 32'(500));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'(0));
        check("arst_wr_en", 32'(wr_en), 32'(0));
        check("arst_wr_addr", 32'(wr_addr), 32'(0));
        check("arst_wr_data", 32'(wr_data), 32'(0));
        check("arst_start_comp", 32'(start_comp), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_image_done", 32'(image_done), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Negative pixel 0x8234 sent as 0x34, 0x82 lands at address 0
        mon_en = 1'b0;
        send_byte(8'h34, 1'b0);
        send_byte(8'h82, 1'b0);
        in_valid = 1'b0;
        check("neg_wr_en", 32'(wr_en), 32'(1));
        check("neg_wr_addr", 32'(wr_addr), 32'(0));
        check("neg_wr_data", 32'(wr_data), 32'h0000_8234);
        @(negedge clk);
        check("neg_wr_en_single", 32'(wr_en), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/mnist_image_loader.md
Name: mnist_image_loader

Overview:
- Writer side of the classifier's image input path: receives a byte stream from a host link and assembles it into signed DATA_WIDTH-bit pixels.
- Writes the pixels sequentially into the image buffer that feeds the systolic-array fetcher.
- Once a full ARRAY_A_L-pixel image is written, issues a one-cycle start_comp pulse, then waits for the completion edge of the compute path's ready.
- Sits between the host interface and the classifier wrapper; replaces ROM-resident images with runtime-loaded ones.

Parameters:
- DATA_WIDTH, 16, pixel width in bits; must be a multiple of 8.
- ARRAY_A_L, 784, pixels per image.
- ADDR_W, 10, width of the buffer address; requires 2^ADDR_W >= ARRAY_A_L.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- abort  input  1  synchronous clear; discards the partial image.
- wr_en  output  1  image-buffer write strobe.
- wr_addr  output  ADDR_W  pixel index being written.
- wr_data  output  DATA_WIDTH  assembled pixel.
- start_comp  output  1  one-cycle active-high compute start.
- comp_ready  input  1  level "result ready" from the compute path.
- busy  output  1  high from the first accepted byte until image_done.
- image_done  output  1  one-cycle pulse when the result for the loaded image is ready.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, start_comp=0, busy=0, image_done=0.
  - State=LOAD, byte_cnt=0, word_cnt=0, comp_ready_prev=0.
  - in_ready rises in the first cycle after reset release.
- Byte handshake: a byte is transferred on a clock edge where in_valid & in_ready. in_ready is a registered output, high only in LOAD; no combinational in_valid->in_ready path.
- Assembly:
  - DATA_WIDTH/8 bytes form one pixel, least-significant byte first.
  - byte_cnt counts 0..DATA_WIDTH/8-1 and wraps.
  - Partial bytes are held in an assembly register.
- Write:
  - On the edge accepting the final byte of a pixel, register wr_en=1, wr_addr=word_cnt, and wr_data={final byte, held bytes}.
  - wr_en is therefore high for exactly the following cycle, i.e. latency is 1 cycle after the last byte.
  - word_cnt then increments. wr_en is 0 in every other cycle.
- Back-to-back bytes at full rate (in_valid held high) produce one write every DATA_WIDTH/8 cycles. Gaps in in_valid stall assembly without loss.
- States:
  - LOAD: in_ready=1. When the write of pixel ARRAY_A_L-1 is registered, next state START and in_ready drops the same edge, so no extra byte is accepted.
  - START: start_comp=1 for exactly one cycle, then WAIT.
  - WAIT: in_ready=0. comp_ready_prev is sampled every cycle in every state. On comp_ready & ~comp_ready_prev, go to DONE.
  - DONE: image_done=1 for one cycle. Clear word_cnt and byte_cnt, return to LOAD.
- A comp_ready that is already high on entering WAIT (stale from the previous image) is ignored until it falls and rises again.
- busy is set on the first accepted byte of an image and cleared in the DONE cycle.
- abort:
  - In any state: next state LOAD, counters cleared, assembly register cleared, busy=0.
  - Any pending wr_en or start_comp is suppressed the next cycle.
  - abort has priority over a simultaneous byte transfer, which is dropped.
- Async reset mid-image behaves as abort with all outputs forced to their reset values immediately.
- Arithmetic: word_cnt is ADDR_W bits and compares against ARRAY_A_L-1; it never wraps past ARRAY_A_L-1. wr_data carries raw bits with no sign manipulation.

Test Plan:
- Reset release, then stream 1568 bytes at full rate: byte pairs (k & 0xFF, k >> 8) for pixel k -> 784 wr_en pulses, wr_addr 0..783 and wr_data=k. start_comp is high exactly one cycle, 1 cycle after the last write. in_ready=0 afterwards.
- Same stream with random in_valid gaps (about 50% duty) -> identical write sequence and values; no duplicate or missing addresses.
- Load image with comp_ready held high from before -> no image_done. Drop comp_ready for 3 cycles, raise it -> image_done exactly one cycle, then in_ready=1 and next image written from wr_addr=0.
- Send 301 bytes, then pulse abort -> no further wr_en, busy=0. A fresh 1568-byte stream restarts at wr_addr=0 with correct LSB-first pairing.
- Assert reset_n=0 asynchronously while wr_en=1 at address 500 -> all outputs 0 immediately. After release, first write lands at address 0.
- Byte 0x34 then 0x82 as pixel 0 -> wr_data=16'h8234 (negative pixel, bits unchanged).
